// File: rtl/riscv_core_pkg.sv
// -----------------------------------------------------------------------------
// riscv_core_pkg
// Shared definitions for the multicycle control sequencer:
//   - supported major opcodes (R, I, L, S, SB)
//   - sequencer state encoding (exported on state_out for debug)
//   - default sequential PC increment
//   - opcode legality helper
// -----------------------------------------------------------------------------
package riscv_core_pkg;

   localparam logic [6:0] R_TYPE  = 7'b0110011;
   localparam logic [6:0] I_TYPE  = 7'b0010011;
   localparam logic [6:0] L_TYPE  = 7'b0000011;
   localparam logic [6:0] S_TYPE  = 7'b0100011;
   localparam logic [6:0] SB_TYPE = 7'b1100011;

   localparam int unsigned PC_STEP_DEFAULT = 32'd4;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      PC_UPDATE = 3'd5
   } state_e;

   // True for the opcodes the sequencer knows how to step through.
   function automatic logic is_legal_opcode(input logic [6:0] op);
      logic legal;
      case (op)
         R_TYPE, I_TYPE, L_TYPE, S_TYPE, SB_TYPE: legal = 1'b1;
         default:                                 legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/riscv_control_fsm_if.sv
// -----------------------------------------------------------------------------
// riscv_control_fsm_if
// Bundles every non-clock/reset signal of the sequencer.
//   slave  : sequencer side (takes instruction/ALU/memory status, drives controls)
//   master : environment side (instruction memory, ALU, data memory, regfile)
// Inputs : instr_in, instr_valid_in, alu_result_in, mem_ready_in
// Outputs: pc_out, en_ifetch_out, Opcode/func3/func7, rs1/rs2/rd addresses,
//          imm_out, alu_src_imm_out, en_regread/en_alu/mem_read/mem_write/
//          en_regwrite strobes, wb_sel_mem_out, illegal_instr_out, state_out
// -----------------------------------------------------------------------------
interface riscv_control_fsm_if #(
   parameter int unsigned PC_WIDTH = 32
);
   logic [31:0]         instr_in;
   logic                instr_valid_in;
   logic [31:0]         alu_result_in;
   logic                mem_ready_in;

   logic [PC_WIDTH-1:0] pc_out;
   logic                en_ifetch_out;
   logic [6:0]          Opcode_out;
   logic [2:0]          func3_out;
   logic [6:0]          func7_out;
   logic [4:0]          rs1_addr_out;
   logic [4:0]          rs2_addr_out;
   logic [4:0]          rd_addr_out;
   logic [31:0]         imm_out;
   logic                alu_src_imm_out;
   logic                en_regread_out;
   logic                en_alu_out;
   logic                mem_read_out;
   logic                mem_write_out;
   logic                en_regwrite_out;
   logic                wb_sel_mem_out;
   logic                illegal_instr_out;
   logic [2:0]          state_out;

   modport slave (
      input  instr_in, instr_valid_in, alu_result_in, mem_ready_in,
      output pc_out, en_ifetch_out, Opcode_out, func3_out, func7_out,
             rs1_addr_out, rs2_addr_out, rd_addr_out, imm_out, alu_src_imm_out,
             en_regread_out, en_alu_out, mem_read_out, mem_write_out,
             en_regwrite_out, wb_sel_mem_out, illegal_instr_out, state_out
   );

   modport master (
      output instr_in, instr_valid_in, alu_result_in, mem_ready_in,
      input  pc_out, en_ifetch_out, Opcode_out, func3_out, func7_out,
             rs1_addr_out, rs2_addr_out, rd_addr_out, imm_out, alu_src_imm_out,
             en_regread_out, en_alu_out, mem_read_out, mem_write_out,
             en_regwrite_out, wb_sel_mem_out, illegal_instr_out, state_out
   );
endinterface

// File: rtl/riscv_imm_gen.sv
// -----------------------------------------------------------------------------
// riscv_imm_gen
// Combinational immediate extractor / sign-extender keyed on the opcode.
//   instr_i : raw 32-bit instruction word
//   imm_o   : sign-extended immediate (0 for R-type and unknown opcodes)
// -----------------------------------------------------------------------------
module riscv_imm_gen
   import riscv_core_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [31:0] imm_o
);
   // rs1/func3 bits never contribute to an immediate in the supported formats
   logic unused_bits_s;
   assign unused_bits_s = ^instr_i[19:12];

   // Select the immediate layout from the opcode.
   always_comb begin
      imm_o = 32'h0000_0000;
      case (instr_i[6:0])
         I_TYPE, L_TYPE: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         S_TYPE:         imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         SB_TYPE:        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                  instr_i[30:25], instr_i[11:8], 1'b0};
         default:        imm_o = 32'h0000_0000;
      endcase
   end
endmodule

// File: rtl/riscv_control_fsm.sv
// -----------------------------------------------------------------------------
// riscv_control_fsm
// Multicycle instruction sequencer: FETCH -> DECODE -> EXECUTE ->
// [MEMORY] -> [WRITEBACK] -> PC_UPDATE. All outputs are registered; every
// strobe is computed from the next state so it is high exactly while the
// sequencer sits in the state that owns it.
//   Clock              : core clock, rising edge
//   peripheral_reset_n : asynchronous active-low reset
//   bus (slave)        : instruction/ALU/memory inputs, control outputs
// Fields and imm are captured when the instruction is accepted in FETCH and
// held until the next accepted instruction. The PC advances on the edge that
// leaves PC_UPDATE, so it is stable for the whole instruction.
// -----------------------------------------------------------------------------
module riscv_control_fsm
   import riscv_core_pkg::*;
#(
   parameter int unsigned         PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}},
   parameter int unsigned         PC_STEP  = PC_STEP_DEFAULT
) (
   input logic                Clock,
   input logic                peripheral_reset_n,
   riscv_control_fsm_if.slave bus
);
   state_e              state_q,   state_d;
   logic [PC_WIDTH-1:0] pc_q,      pc_d;
   logic [6:0]          opcode_q,  opcode_d;
   logic [2:0]          func3_q,   func3_d;
   logic [6:0]          func7_q,   func7_d;
   logic [4:0]          rs1_q,     rs1_d;
   logic [4:0]          rs2_q,     rs2_d;
   logic [4:0]          rd_q,      rd_d;
   logic [31:0]         imm_q,     imm_d;
   logic                src_imm_q, src_imm_d;
   logic                taken_q,   taken_d;
   logic                ifetch_q,  ifetch_d;
   logic                regread_q, regread_d;
   logic                alu_q,     alu_d;
   logic                mem_rd_q,  mem_rd_d;
   logic                mem_wr_q,  mem_wr_d;
   logic                regwr_q,   regwr_d;
   logic                wbsel_q,   wbsel_d;
   logic                illegal_q, illegal_d;
   logic [31:0]         imm_gen_s;

   riscv_imm_gen u_imm_gen (
      .instr_i (bus.instr_in),
      .imm_o   (imm_gen_s)
   );

   // Next-state, captured fields, branch decision, PC and registered strobes.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      opcode_d  = opcode_q;
      func3_d   = func3_q;
      func7_d   = func7_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      imm_d     = imm_q;
      src_imm_d = src_imm_q;
      taken_d   = taken_q;

      case (state_q)
         FETCH: begin
            if (bus.instr_valid_in) begin
               state_d   = DECODE;
               opcode_d  = bus.instr_in[6:0];
               func3_d   = bus.instr_in[14:12];
               func7_d   = bus.instr_in[31:25];
               rs1_d     = bus.instr_in[19:15];
               rs2_d     = bus.instr_in[24:20];
               rd_d      = bus.instr_in[11:7];
               imm_d     = imm_gen_s;
               src_imm_d = (bus.instr_in[6:0] == I_TYPE) ||
                           (bus.instr_in[6:0] == L_TYPE) ||
                           (bus.instr_in[6:0] == S_TYPE);
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            // Clear so an illegal instruction (which skips EXECUTE) steps by PC_STEP
            taken_d = 1'b0;
            if (is_legal_opcode(opcode_q)) begin
               state_d = EXECUTE;
            end else begin
               state_d = PC_UPDATE;
            end
         end
         EXECUTE: begin
            case (opcode_q)
               L_TYPE, S_TYPE: state_d = MEMORY;
               SB_TYPE:        state_d = PC_UPDATE;
               default:        state_d = WRITEBACK;
            endcase
            // BEQ compares via XOR (zero means equal); other branches take on non-zero
            if (opcode_q == SB_TYPE) begin
               if (func3_q == 3'b000) begin
                  taken_d = (bus.alu_result_in == 32'h0000_0000);
               end else begin
                  taken_d = (bus.alu_result_in != 32'h0000_0000);
               end
            end else begin
               taken_d = 1'b0;
            end
         end
         MEMORY: begin
            if (bus.mem_ready_in) begin
               if (opcode_q == L_TYPE) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = PC_UPDATE;
               end
            end else begin
               state_d = MEMORY;
            end
         end
         WRITEBACK: begin
            state_d = PC_UPDATE;
         end
         PC_UPDATE: begin
            state_d = FETCH;
            if (taken_q) begin
               pc_d = pc_q + PC_WIDTH'(imm_q);
            end else begin
               pc_d = pc_q + PC_WIDTH'(PC_STEP);
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      ifetch_d  = (state_d == FETCH);
      regread_d = (state_d == DECODE);
      illegal_d = (state_d == DECODE) && !is_legal_opcode(opcode_d);
      alu_d     = (state_d == EXECUTE);
      mem_rd_d  = (state_d == MEMORY) && (opcode_d == L_TYPE);
      mem_wr_d  = (state_d == MEMORY) && (opcode_d == S_TYPE);
      regwr_d   = (state_d == WRITEBACK) && (rd_d != 5'd0);
      wbsel_d   = (state_d == WRITEBACK) && (opcode_d == L_TYPE);
   end

   // State, PC, field and strobe registers; reset abandons any pending handshake.
   always_ff @(posedge Clock or negedge peripheral_reset_n) begin
      if (!peripheral_reset_n) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         opcode_q  <= 7'd0;
         func3_q   <= 3'd0;
         func7_q   <= 7'd0;
         rs1_q     <= 5'd0;
         rs2_q     <= 5'd0;
         rd_q      <= 5'd0;
         imm_q     <= 32'h0000_0000;
         src_imm_q <= 1'b0;
         taken_q   <= 1'b0;
         ifetch_q  <= 1'b0;
         regread_q <= 1'b0;
         alu_q     <= 1'b0;
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
         regwr_q   <= 1'b0;
         wbsel_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         opcode_q  <= opcode_d;
         func3_q   <= func3_d;
         func7_q   <= func7_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
         imm_q     <= imm_d;
         src_imm_q <= src_imm_d;
         taken_q   <= taken_d;
         ifetch_q  <= ifetch_d;
         regread_q <= regread_d;
         alu_q     <= alu_d;
         mem_rd_q  <= mem_rd_d;
         mem_wr_q  <= mem_wr_d;
         regwr_q   <= regwr_d;
         wbsel_q   <= wbsel_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.pc_out            = pc_q;
   assign bus.en_ifetch_out     = ifetch_q;
   assign bus.Opcode_out        = opcode_q;
   assign bus.func3_out         = func3_q;
   assign bus.func7_out         = func7_q;
   assign bus.rs1_addr_out      = rs1_q;
   assign bus.rs2_addr_out      = rs2_q;
   assign bus.rd_addr_out       = rd_q;
   assign bus.imm_out           = imm_q;
   assign bus.alu_src_imm_out   = src_imm_q;
   assign bus.en_regread_out    = regread_q;
   assign bus.en_alu_out        = alu_q;
   assign bus.mem_read_out      = mem_rd_q;
   assign bus.mem_write_out     = mem_wr_q;
   assign bus.en_regwrite_out   = regwr_q;
   assign bus.wb_sel_mem_out    = wbsel_q;
   assign bus.illegal_instr_out = illegal_q;
   assign bus.state_out         = state_q;
endmodule
